// File: rtl/id_ex_hazard_stage.sv
// id_ex_hazard_stage
//   ID/EX pipeline register with load-use hazard detection. Holds the EX-stage
//   operand set (operands, source/destination indices, extend selector and
//   control) consumed by the ALU forwarding unit. When a decoded source depends
//   on a load still in EX, decode is stalled and LOAD_LAT bubbles are inserted.
//
// Parameters
//   LOAD_LAT      bubbles inserted per load-use hazard (1..7)
//
// Ports
//   clk, rst_n    clock; synchronous active-low reset
//   id_*          decoded instruction fields from the ID stage
//   flush         branch flush of the ID/EX slot (highest priority after reset)
//   ex_hold       downstream freeze; all state holds
//   stall_id      hold PC and IF/ID this cycle (combinational)
//   r2res3, r3res3, r2_2, r3_2, extnd_sel1, dest_r_3,
//   wr_en_3, is_load_3, valid_3   registered EX-stage operand set
//   stall_count   (HAZARD_STATS_EN only) saturating count of hazard bubbles
//
// Build option
//   HAZARD_STATS_EN  adds the stall_count output and its counter.
module id_ex_hazard_stage #(
  parameter int unsigned LOAD_LAT = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        id_valid,
  input  logic [31:0] id_r2_data,
  input  logic [31:0] id_r3_data,
  input  logic [3:0]  id_r2_idx,
  input  logic [3:0]  id_r3_idx,
  input  logic [3:0]  id_dest_idx,
  input  logic [1:0]  id_extnd_sel,
  input  logic        id_wr_en,
  input  logic        id_is_load,
  input  logic        flush,
  input  logic        ex_hold,
`ifdef HAZARD_STATS_EN
  output logic [31:0] stall_count,
`endif
  output logic        stall_id,
  output logic [31:0] r2res3,
  output logic [31:0] r3res3,
  output logic [3:0]  r2_2,
  output logic [3:0]  r3_2,
  output logic [1:0]  extnd_sel1,
  output logic [3:0]  dest_r_3,
  output logic        wr_en_3,
  output logic        is_load_3,
  output logic        valid_3
);

  typedef enum logic {RUN, STALL} state_t;

  state_t     r_state;
  state_t     w_state_nxt;
  logic [2:0] r_cnt;
  logic [2:0] w_cnt_nxt;
  logic       w_hazard;
  logic       w_bubble;
  logic       w_capture;
  logic       w_stat_inc;

  // Index 0 is compared like any other; a bubble carries dest 0 but also
  // valid_3=0, so it can never raise a hazard by itself.
  assign w_hazard = id_valid & valid_3 & is_load_3 & wr_en_3 & ~id_extnd_sel[1] &
                    ((id_r2_idx == dest_r_3) | (id_r3_idx == dest_r_3));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= RUN;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_bubble    = 1'b0;
    w_capture   = 1'b0;
    w_stat_inc  = 1'b0;
    if (flush) begin
      w_bubble    = 1'b1;
      w_state_nxt = RUN;
      w_cnt_nxt   = '0;
    end else if (ex_hold) begin
      // everything holds
    end else if (r_state == RUN) begin
      if (w_hazard) begin
        w_bubble   = 1'b1;
        w_stat_inc = 1'b1;
        if (LOAD_LAT > 1) begin
          w_state_nxt = STALL;
          w_cnt_nxt   = 3'(LOAD_LAT - 1);
        end
      end else begin
        w_capture = 1'b1;
      end
    end else begin
      w_bubble   = 1'b1;
      w_stat_inc = 1'b1;
      w_cnt_nxt  = r_cnt - 3'd1;
      if (r_cnt == 3'd1) begin
        w_state_nxt = RUN;
      end
    end
  end

  assign stall_id = ~flush & (ex_hold | (r_state == STALL) | ((r_state == RUN) & w_hazard));

  always_ff @(posedge clk) begin
    if (!rst_n || w_bubble) begin
      r2res3     <= '0;
      r3res3     <= '0;
      r2_2       <= '0;
      r3_2       <= '0;
      extnd_sel1 <= '0;
      dest_r_3   <= '0;
      wr_en_3    <= 1'b0;
      is_load_3  <= 1'b0;
      valid_3    <= 1'b0;
    end else if (w_capture) begin
      r2res3     <= id_r2_data;
      r3res3     <= id_r3_data;
      r2_2       <= id_r2_idx;
      r3_2       <= id_r3_idx;
      extnd_sel1 <= id_extnd_sel;
      dest_r_3   <= id_dest_idx;
      wr_en_3    <= id_wr_en;
      is_load_3  <= id_is_load;
      valid_3    <= id_valid;
    end
  end

`ifdef HAZARD_STATS_EN
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      stall_count <= '0;
    end else if (w_stat_inc && (stall_count != '1)) begin
      stall_count <= stall_count + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_id_ex_hazard_stage.sv
// Directed bench for id_ex_hazard_stage. Three instances share stimulus:
// index 0 has LOAD_LAT=1, index 1 LOAD_LAT=2, index 2 LOAD_LAT=3.
module tb_id_ex_hazard_stage;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        id_valid;
  logic [31:0] id_r2_data, id_r3_data;
  logic [3:0]  id_r2_idx, id_r3_idx, id_dest_idx;
  logic [1:0]  id_extnd_sel;
  logic        id_wr_en, id_is_load, flush, ex_hold;

  logic        stall_id   [3];
  logic [31:0] r2res3     [3];
  logic [31:0] r3res3     [3];
  logic [3:0]  r2_2       [3];
  logic [3:0]  r3_2       [3];
  logic [1:0]  extnd_sel1 [3];
  logic [3:0]  dest_r_3   [3];
  logic        wr_en_3    [3];
  logic        is_load_3  [3];
  logic        valid_3    [3];
`ifdef HAZARD_STATS_EN
  logic [31:0] stall_count [3];
`endif

  int n_cmp = 0;
  int n_err = 0;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    id_ex_hazard_stage #(.LOAD_LAT(g + 1)) u_dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .id_valid     (id_valid),
      .id_r2_data   (id_r2_data),
      .id_r3_data   (id_r3_data),
      .id_r2_idx    (id_r2_idx),
      .id_r3_idx    (id_r3_idx),
      .id_dest_idx  (id_dest_idx),
      .id_extnd_sel (id_extnd_sel),
      .id_wr_en     (id_wr_en),
      .id_is_load   (id_is_load),
      .flush        (flush),
      .ex_hold      (ex_hold),
`ifdef HAZARD_STATS_EN
      .stall_count  (stall_count[g]),
`endif
      .stall_id     (stall_id[g]),
      .r2res3       (r2res3[g]),
      .r3res3       (r3res3[g]),
      .r2_2         (r2_2[g]),
      .r3_2         (r3_2[g]),
      .extnd_sel1   (extnd_sel1[g]),
      .dest_r_3     (dest_r_3[g]),
      .wr_en_3      (wr_en_3[g]),
      .is_load_3    (is_load_3[g]),
      .valid_3      (valid_3[g])
    );
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    id_valid = 1'b0; id_r2_data = '0; id_r3_data = '0;
    id_r2_idx = '0; id_r3_idx = '0; id_dest_idx = '0; id_extnd_sel = '0;
    id_wr_en = 1'b0; id_is_load = 1'b0; flush = 1'b0; ex_hold = 1'b0;
  endtask

  // Load writing R4.
  task automatic drive_load();
    id_valid = 1'b1; id_r2_data = 32'h0000_1111; id_r3_data = 32'h0000_2222;
    id_r2_idx = 4'd1; id_r3_idx = 4'd2; id_dest_idx = 4'd4; id_extnd_sel = 2'b00;
    id_wr_en = 1'b1; id_is_load = 1'b1;
  endtask

  // ALU op reading R4, writing R8.
  task automatic drive_dep(input logic [1:0] ext);
    id_valid = 1'b1; id_r2_data = 32'hAAAA_0004; id_r3_data = 32'hBBBB_0007;
    id_r2_idx = 4'd4; id_r3_idx = 4'd7; id_dest_idx = 4'd8; id_extnd_sel = ext;
    id_wr_en = 1'b1; id_is_load = 1'b0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    #1;
  endtask

  initial begin
    idle();
    rst_n = 1'b0;

    // Reset with random inputs
    for (int c = 0; c < 2; c++) begin
      id_valid = 1'($urandom); id_r2_data = $urandom; id_r3_data = $urandom;
      id_r2_idx = 4'($urandom); id_r3_idx = 4'($urandom); id_dest_idx = 4'($urandom);
      id_extnd_sel = 2'($urandom); id_wr_en = 1'($urandom); id_is_load = 1'($urandom);
      flush = 1'($urandom); ex_hold = 1'b0;
      tick();
    end
    for (int i = 0; i < 3; i++) begin
      chk("rst_r2res3", r2res3[i], 32'h0);
      chk("rst_r3res3", r3res3[i], 32'h0);
      chk("rst_dest", 32'(dest_r_3[i]), 32'h0);
      chk("rst_ctl", {29'h0, wr_en_3[i], is_load_3[i], valid_3[i]}, 32'h0);
      chk("rst_idx", {24'h0, r2_2[i], r3_2[i]}, 32'h0);
      chk("rst_ext", 32'(extnd_sel1[i]), 32'h0);
    end
    idle();
    rst_n = 1'b1;
    #1;
    for (int i = 0; i < 3; i++) chk("rst_stall", 32'(stall_id[i]), 32'h0);

    // Pass-through
    id_valid = 1'b1; id_r2_data = 32'h0000_1234; id_r2_idx = 4'd3;
    id_r3_idx = 4'd6; id_dest_idx = 4'd5; id_wr_en = 1'b1;
    #1;
    chk("pt_stall_pre", 32'(stall_id[0]), 32'h0);
    tick();
    chk("pt_r2res3", r2res3[0], 32'h0000_1234);
    chk("pt_r2_2", 32'(r2_2[0]), 32'd3);
    chk("pt_dest", 32'(dest_r_3[0]), 32'd5);
    chk("pt_valid", 32'(valid_3[0]), 32'd1);
    chk("pt_stall", 32'(stall_id[0]), 32'h0);

    // Load-use hazard on all three latencies
    idle(); do_reset();
    drive_load();
    tick();
    chk("lu_load_in_ex", {28'h0, dest_r_3[2]}, 32'd4);
    drive_dep(2'b00);
    #1;
    chk("lu_stall_l1", 32'(stall_id[0]), 32'd1);
    chk("lu_stall_l3", 32'(stall_id[2]), 32'd1);
    tick(); // edge 1
    chk("lu1_bubble_dest", 32'(dest_r_3[0]), 32'h0);
    chk("lu1_bubble_valid", 32'(valid_3[0]), 32'h0);
    chk("lu1_stall_after", 32'(stall_id[0]), 32'h0);
    chk("lu3_b1_dest", 32'(dest_r_3[2]), 32'h0);
    chk("lu3_b1_stall", 32'(stall_id[2]), 32'd1);
    chk("lu2_b1_stall", 32'(stall_id[1]), 32'd1);
    tick(); // edge 2
    chk("lu1_cap_data", r2res3[0], 32'hAAAA_0004);
    chk("lu1_cap_dest", 32'(dest_r_3[0]), 32'd8);
    chk("lu1_cap_valid", 32'(valid_3[0]), 32'd1);
    chk("lu2_b2_dest", 32'(dest_r_3[1]), 32'h0);
    chk("lu2_b2_stall", 32'(stall_id[1]), 32'h0);
    chk("lu3_b2_dest", 32'(dest_r_3[2]), 32'h0);
    chk("lu3_b2_stall", 32'(stall_id[2]), 32'd1);
    tick(); // edge 3
    chk("lu2_cap_dest", 32'(dest_r_3[1]), 32'd8);
    chk("lu3_b3_dest", 32'(dest_r_3[2]), 32'h0);
    chk("lu3_b3_valid", 32'(valid_3[2]), 32'h0);
    chk("lu3_b3_stall", 32'(stall_id[2]), 32'h0);
    tick(); // edge 4
    chk("lu3_cap_dest", 32'(dest_r_3[2]), 32'd8);
    chk("lu3_cap_r3", r3res3[2], 32'hBBBB_0007);
    chk("lu3_cap_valid", 32'(valid_3[2]), 32'd1);

    // Immediate-type sources never hazard
    idle(); do_reset();
    drive_load(); tick();
    drive_dep(2'b10);
    #1;
    chk("ext_no_stall", 32'(stall_id[2]), 32'h0);
    tick();
    chk("ext_cap_dest", 32'(dest_r_3[2]), 32'd8);
    chk("ext_cap_sel", 32'(extnd_sel1[2]), 32'd2);

    // Hazard on r3 index 0 against a load writing R0
    idle(); do_reset();
    drive_load(); id_dest_idx = 4'd0; tick();
    drive_dep(2'b00); id_r2_idx = 4'd9; id_r3_idx = 4'd0;
    #1;
    chk("r0_stall", 32'(stall_id[0]), 32'd1);

    // Flush on the second bubble cycle of a LOAD_LAT=3 stall
    idle(); do_reset();
    drive_load(); tick();
    drive_dep(2'b00);
    tick(); // edge 1: u3 in STALL
    flush = 1'b1;
    #1;
    chk("fl_stall", 32'(stall_id[2]), 32'h0);
    tick(); // flush bubble
    chk("fl_dest", 32'(dest_r_3[2]), 32'h0);
    flush = 1'b0;
    #1;
    chk("fl_run_stall", 32'(stall_id[2]), 32'h0);
    tick();
    chk("fl_cap_dest", 32'(dest_r_3[2]), 32'd8);
    chk("fl_cap_data", r2res3[2], 32'hAAAA_0004);

    // Downstream hold for two cycles
    id_r2_data = 32'h0000_5555; id_dest_idx = 4'd9; id_r2_idx = 4'd2;
    ex_hold = 1'b1;
    #1;
    chk("hold_stall", 32'(stall_id[2]), 32'd1);
    tick(); tick();
    chk("hold_dest", 32'(dest_r_3[2]), 32'd8);
    chk("hold_data", r2res3[2], 32'hAAAA_0004);
    ex_hold = 1'b0;
    tick();
    chk("unhold_dest", 32'(dest_r_3[2]), 32'd9);
    chk("unhold_data", r2res3[2], 32'h0000_5555);

    // flush and hold together: flush wins
    ex_hold = 1'b1; flush = 1'b1;
    #1;
    chk("fh_stall", 32'(stall_id[2]), 32'h0);
    tick();
    chk("fh_dest", 32'(dest_r_3[2]), 32'h0);
    chk("fh_valid", 32'(valid_3[2]), 32'h0);

    // Reset during STALL
    idle(); do_reset();
    drive_load(); tick();
    drive_dep(2'b00); tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    idle();
    #1;
    chk("rs_stall", 32'(stall_id[2]), 32'h0);
    tick();
    chk("rs_valid", 32'(valid_3[2]), 32'h0);

`ifdef HAZARD_STATS_EN
    // Two LOAD_LAT=2 hazards plus a flush
    idle(); do_reset();
    chk("st_clear", stall_count[1], 32'h0);
    for (int k = 0; k < 2; k++) begin
      drive_load(); tick();
      drive_dep(2'b00); tick(); tick(); tick();
    end
    idle();
    flush = 1'b1; tick();
    flush = 1'b0;
    chk("st_count", stall_count[1], 32'd4);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/id_ex_hazard_stage.md
# id_ex_hazard_stage

ID/EX pipeline register with load-use hazard detection, directly upstream of the ALU forwarding unit. It latches decoded operands, source and destination indices, and the extend selector. It supplies them to the forwarding unit as the EX-stage operand set. It also stalls decode and inserts bubbles when a source register depends on a load still in EX, since forwarding cannot cover that case.

## Interface
- LOAD_LAT, 1: bubbles inserted per load-use hazard; legal range 1..7.
- clk  in  1  clock; all state updates on rising edge.
- rst_n  in  1  synchronous, active-low reset.
- id_valid  in  1  decode holds a valid instruction.
- id_r2_data, id_r3_data  in  32  register-file read data.
- id_r2_idx, id_r3_idx  in  4  source register indices.
- id_dest_idx  in  4  destination index.
- id_extnd_sel  in  2  extend selector; bit 1 set means sources are not registers.
- id_wr_en, id_is_load  in  1  writes a register / is a load.
- flush  in  1  branch flush of the ID/EX slot.
- ex_hold  in  1  downstream freeze.
- stall_id  out  1  hold PC and IF/ID this cycle.
- r2res3, r3res3  out  32  registered operands.
- r2_2, r3_2  out  4  registered source indices.
- extnd_sel1  out  2  registered extend selector.
- dest_r_3  out  4  registered destination index.
- wr_en_3, is_load_3, valid_3  out  1  registered control.

## Operation
- hazard = id_valid & valid_3 & is_load_3 & wr_en_3 & ~id_extnd_sel[1] & (id_r2_idx==dest_r_3 | id_r3_idx==dest_r_3). Combinational.
- A bubble loads all outputs as zero, including dest_r_3=0. R0 is the hardwired zero register, so a bubble forwards 0, which is R0's true value.
- FSM states are RUN and STALL. The counter cnt is 3 bits.
- Per-edge priority, highest first:
  - **!rst_n:** all outputs 0, state RUN, cnt 0.
  - **flush:** load bubble, state RUN, cnt 0.
  - **ex_hold:** all registers, state and cnt hold.
  - **RUN & hazard:** load bubble. If LOAD_LAT>1, go to STALL with cnt=LOAD_LAT-1. Otherwise stay in RUN.
  - **RUN & ~hazard:** capture the id_* inputs. valid_3 = id_valid.
  - **STALL:** load bubble and decrement cnt. Go to RUN when cnt==1.
- stall_id = ~flush & (ex_hold | state==STALL | (state==RUN & hazard)).
- Index 0 is compared like any other index; no special casing.

## Timing
- Capture latency is one cycle: id_* sampled at edge N appear on outputs after edge N.
- A hazard costs exactly LOAD_LAT bubbles. The dependent instruction is captured on edge N+LOAD_LAT, when the load has reached a stage covered by WB forwarding.
- stall_id is combinational and valid in the same cycle hazard is true.
- flush and ex_hold together: flush wins.
- Hazard while ex_hold is high: stall_id is high, and nothing advances until hold drops.
- Reset during STALL: the next cycle is RUN with a zeroed slot.

## Configuration
- **HAZARD_STATS_EN defined:**
  - Adds output stall_count (32 bits): increments on every bubble inserted because of a hazard or STALL, excluding flush and hold.
  - Saturates at 0xFFFFFFFF.
  - Clears on reset.
- **Not defined:** no port and no counter logic. All other behaviour is identical.

## Test plan
- Reset: rst_n=0 for 2 cycles with random inputs -> all outputs 0, stall_id=0 after release with id_valid=0.
- Pass-through: id_r2_data=0x1234, id_r2_idx=3, id_dest_idx=5, no hazard -> next cycle r2res3=0x1234, r2_2=3, dest_r_3=5, valid_3=1, stall_id=0.
- Load-use, LOAD_LAT=1: load to R4 in EX, decode reads R4 -> stall_id=1 for one cycle, one bubble (dest_r_3=0), instruction captured on the next edge.
- Load-use, LOAD_LAT=3: same stimulus -> three consecutive bubbles, stall_id=1 for three cycles, then capture. Same stimulus with id_extnd_sel=2'b10 -> no stall.
- Flush mid-STALL (LOAD_LAT=3, flush on second bubble cycle) -> bubble, state RUN, stall_id=0 that cycle. ex_hold=1 for 2 cycles -> outputs unchanged.
- HAZARD_STATS_EN: two LOAD_LAT=2 hazards plus one flush -> stall_count=4.
